// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: multi-precision sequencer driving a 4-bit ALU one nibble per cycle, LSB first
//   params : NIBBLES - operand width in nibbles (1..8), W = 4*NIBBLES
//   cmd    : cmd_valid/cmd_ready handshake, cmd_op (alu_4b S encoding, 111 illegal), cmd_a, cmd_b
//   res    : res_valid/res_ready handshake, res_data, res_cout, res_err, res_zero
//   alu    : alu_a, alu_b, alu_s, alu_cin out to alu_4b; alu_f, alu_cout back in the same cycle
//   macro  : ALU_SEQ_ZFLAG_EN builds the res_zero detector; otherwise res_zero is tied to 0
module alu_seq_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [2:0]           cmd_op,
    input  logic [4*NIBBLES-1:0] cmd_a,
    input  logic [4*NIBBLES-1:0] cmd_b,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [4*NIBBLES-1:0] res_data,
    output logic                 res_cout,
    output logic                 res_err,
    output logic                 res_zero,
    output logic [3:0]           alu_a,
    output logic [3:0]           alu_b,
    output logic [2:0]           alu_s,
    output logic                 alu_cin,
    input  logic [3:0]           alu_f,
    input  logic                 alu_cout
);
    localparam int W = 4 * NIBBLES;
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
    state_t       state;
    logic [W-1:0] a_r, b_r, data_nx;
    logic [3:0]   idx;
    logic         arith, last, carry_nx;
    // alu_s holds the latched opcode for the whole EXEC phase; alu_cin is the carry register
    always_comb begin
        arith    = alu_s == 3'b001 || alu_s == 3'b010;
        last     = idx == 4'(NIBBLES - 1);
        carry_nx = arith && alu_cout;
        data_nx  = (res_data >> 4) | (W'(alu_f) << (W - 4));
    end
    // result nibbles enter at the top and shift down, so nibble 0 lands at the bottom after NIBBLES steps
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_cout  <= 1'b0;
            res_err   <= 1'b0;
            a_r       <= '0;
            b_r       <= '0;
            idx       <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_s     <= '0;
            alu_cin   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (cmd_valid) begin
                    res_data  <= '0;
                    res_cout  <= 1'b0;
                    idx       <= '0;
                    cmd_ready <= 1'b0;
                    if (cmd_op == 3'b111) begin
                        res_err   <= 1'b1;
                        res_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        res_err <= 1'b0;
                        alu_a   <= cmd_a[3:0];
                        alu_b   <= cmd_b[3:0];
                        alu_s   <= cmd_op;
                        alu_cin <= cmd_op == 3'b010;
                        a_r     <= cmd_a >> 4;
                        b_r     <= cmd_b >> 4;
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    res_data <= data_nx;
                    idx      <= idx + 4'd1;
                    alu_a    <= last ? 4'd0 : a_r[3:0];
                    alu_b    <= last ? 4'd0 : b_r[3:0];
                    alu_s    <= last ? 3'd0 : alu_s;
                    alu_cin  <= last ? 1'b0 : carry_nx;
                    a_r      <= a_r >> 4;
                    b_r      <= b_r >> 4;
                    if (last) begin
                        res_cout  <= carry_nx;
                        res_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: if (res_ready) begin
                    res_valid <= 1'b0;
                    cmd_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                    res_valid <= 1'b0;
                end
            endcase
        end
    end
`ifdef ALU_SEQ_ZFLAG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            res_zero <= 1'b0;
        else if (state == IDLE && cmd_valid)
            res_zero <= 1'b0;
        else if (state == EXEC && last)
            res_zero <= data_nx == '0;
    end
`else
    assign res_zero = 1'b0;
`endif
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: directed and random checks of alu_seq_ctrl against an arithmetic reference model
module tb_alu_seq_ctrl;
    localparam int N = 4;
    localparam int W = 16;
    logic         clk = 1'b0, rst_n = 1'b1;
    logic         cmd_valid = 1'b0, cmd_ready, res_valid, res_ready = 1'b1;
    logic [2:0]   cmd_op = '0, alu_s;
    logic [W-1:0] cmd_a = '0, cmd_b = '0, res_data;
    logic         res_cout, res_err, res_zero, alu_cin, alu_cout;
    logic [3:0]   alu_a, alu_b, alu_f;
    logic [4:0]   alu_sum;
    int           total = 0, bad = 0;
    always #5 clk = ~clk;
    alu_seq_ctrl #(.NIBBLES(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_cout(res_cout), .res_err(res_err), .res_zero(res_zero),
        .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_cin(alu_cin),
        .alu_f(alu_f), .alu_cout(alu_cout)
    );
    always_comb begin
        case (alu_s)
            3'b000:  alu_sum = {1'b0, alu_a};
            3'b001:  alu_sum = {1'b0, alu_a} + {1'b0, alu_b} + {4'd0, alu_cin};
            3'b010:  alu_sum = {1'b0, alu_a} + {1'b0, ~alu_b} + {4'd0, alu_cin};
            3'b011:  alu_sum = {1'b0, alu_a & alu_b};
            3'b100:  alu_sum = {1'b0, alu_a | alu_b};
            3'b101:  alu_sum = {1'b0, alu_a ^ alu_b};
            3'b110:  alu_sum = {1'b0, ~alu_a};
            default: alu_sum = '0;
        endcase
        {alu_cout, alu_f} = alu_sum;
    end
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    function automatic void model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] d, output logic c, output logic e,
                                  output logic [3:0] cins);
        int ai = int'(a);
        int bi = int'(b);
        d = '0; c = 1'b0; e = 1'b0; cins = '0;
        for (int i = 0; i < 4; i++) begin
            int m = (1 << (4 * i)) - 1;
            if (op == 3'd1) cins[i] = (((ai & m) + (bi & m)) >> (4 * i)) != 0;
            if (op == 3'd2) cins[i] = (ai & m) >= (bi & m);
        end
        case (op)
            3'd0: d = a;
            3'd1: begin d = a + b; c = (ai + bi) > 65535; end
            3'd2: begin d = a - b; c = ai >= bi; end
            3'd3: d = a & b;
            3'd4: d = a | b;
            3'd5: d = a ^ b;
            3'd6: d = ~a;
            default: e = 1'b1;
        endcase
    endfunction
    task automatic issue(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        int n = 0;
        cmd_op = op; cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
        while (!cmd_ready && n < 30) begin
            @(posedge clk); #1; n++;
        end
        if (!cmd_ready) chk("cmd_ready_timeout", 32'(cmd_ready), 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask
    task automatic collect(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b, input int hold,
                           input logic offer, input logic [2:0] oop, input logic [15:0] oa, input logic [15:0] ob);
        logic [15:0] ed;
        logic        ec, ee, ez;
        logic [3:0]  ecin, seq;
        logic [2:0]  s_or;
        int          lat;
        model(op, a, b, ed, ec, ee, ecin);
`ifdef ALU_SEQ_ZFLAG_EN
        ez = ed == 16'd0 && !ee;
`else
        ez = 1'b0;
`endif
        seq = '0; s_or = '0; lat = 0;
        res_ready = hold == 0;
        while (!res_valid && lat < 20) begin
            if (lat < 4) seq[lat] = alu_cin;
            s_or |= alu_s;
            @(posedge clk); #1; lat++;
        end
        chk("latency", lat, ee ? 0 : N);
        chk("res_data", res_data, ed);
        chk("res_cout", res_cout, ec);
        chk("res_err", res_err, ee);
        chk("res_zero", res_zero, ez);
        if (!ee) chk("cin_seq", seq, ecin);
        chk("alu_s_exec", s_or, ee ? 3'd0 : op);
        chk("alu_idle", {alu_a, alu_b, alu_s, alu_cin}, 0);
        for (int h = 0; h < hold; h++) begin
            if (offer) begin
                cmd_op = oop; cmd_a = oa; cmd_b = ob; cmd_valid = 1'b1;
            end
            @(posedge clk); #1;
            chk("hold_valid", res_valid, 1);
            chk("hold_data", res_data, ed);
            chk("hold_flags", {res_cout, res_err, res_zero}, {ec, ee, ez});
            chk("hold_cmd_ready", cmd_ready, 0);
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        chk("hs_valid", res_valid, 0);
        chk("hs_cmd_ready", cmd_ready, 1);
    endtask
    task automatic run(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b, input int hold);
        issue(op, a, b);
        collect(op, a, b, hold, 1'b0, 3'd0, 16'd0, 16'd0);
    endtask
    initial begin
        logic seen;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_res", {res_valid, res_cout, res_err, res_zero}, 0);
        chk("rst_data", res_data, 0);
        chk("rst_alu", {alu_a, alu_b, alu_s, alu_cin}, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        run(3'd1, 16'hFFFF, 16'h0001, 0);
        run(3'd2, 16'h1234, 16'h0235, 0);
        run(3'd2, 16'h0003, 16'h0007, 0);
        run(3'd5, 16'hA5A5, 16'h0FF0, 0);
        run(3'd6, 16'h00F0, 16'h0000, 0);
        issue(3'd1, 16'h1111, 16'h2222);
        collect(3'd1, 16'h1111, 16'h2222, 3, 1'b1, 3'd4, 16'h0F0F, 16'h3030);
        issue(3'd4, 16'h0F0F, 16'h3030);
        collect(3'd4, 16'h0F0F, 16'h3030, 0, 1'b0, 3'd0, 16'd0, 16'd0);
        run(3'd7, 16'h1234, 16'h5678, 1);
        run(3'd0, 16'h0000, 16'hFFFF, 0);
        issue(3'd1, 16'h1234, 16'h5678);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_cmd_ready", cmd_ready, 1);
        chk("mid_rst_res", {res_valid, res_cout, res_err, res_zero}, 0);
        chk("mid_rst_data", res_data, 0);
        chk("mid_rst_alu", {alu_a, alu_b, alu_s, alu_cin}, 0);
        #2 rst_n = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            seen |= res_valid;
        end
        chk("mid_rst_no_result", seen, 0);
        chk("mid_rst_ready", cmd_ready, 1);
        repeat (40) begin
            logic [2:0]  op;
            logic [15:0] a, b;
            op = 3'($urandom_range(0, 7));
            a = 16'($urandom);
            b = ($urandom_range(0, 5) == 0) ? a : 16'($urandom);
            run(op, a, b, $urandom_range(0, 2));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_seq_ctrl.md
# alu_seq_ctrl

- Multi-precision command sequencer: the initiating end of the `alu_4b` interface.
- Accepts one wide operation per valid/ready handshake and drives the combinational 4-bit ALU one nibble per cycle, least-significant first.
- Chains the carry between nibbles and returns the assembled result with its final carry on a valid/ready result channel.
- Sits between the control front-end and an `alu_4b` instance wired to its `alu_*` ports.

## Interface
- `NIBBLES`, 4: operand width in nibbles; data width W = 4*NIBBLES; legal range 1..8.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  block can accept a command (high only in IDLE).
- `cmd_op`  in  3  opcode, same encoding as `alu_4b` S: 000 pass A, 001 add, 010 sub, 011 AND, 100 OR, 101 XOR, 110 NOT A, 111 illegal.
- `cmd_a`, `cmd_b`  in  W  operands.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  consumer takes result.
- `res_data`  out  W  result.
- `res_cout`  out  1  final carry (add) / no-borrow (sub); 0 for all other ops.
- `res_err`  out  1  command had illegal opcode.
- `res_zero`  out  1  result equals zero (see Configuration).
- `alu_a`, `alu_b`  out  4  nibble operands to `alu_4b` A/B.
- `alu_s`  out  3  to `alu_4b` S.
- `alu_cin`  out  1  to `alu_4b` Cin.
- `alu_f`  in  4  from `alu_4b` F.
- `alu_cout`  in  1  from `alu_4b` Cout.

## Operation
- FSM states: IDLE, EXEC, DONE.
- IDLE, on `cmd_valid && cmd_ready`:
  - latch `cmd_a`, `cmd_b`, `cmd_op`; clear nibble index to 0.
  - carry register set to 1 for sub, 0 otherwise.
  - opcode 111: go to DONE with `res_err`=1, `res_data`=0, `res_cout`=0.
  - any other opcode: go to EXEC.
- EXEC:
  - `alu_a`/`alu_b` = operand nibble[idx]; `alu_s` = latched op; `alu_cin` = carry register.
  - Each edge: `alu_f` written to `res_data` nibble[idx]; for add/sub, carry register updated from `alu_cout`; idx increments.
  - After nibble NIBBLES-1 is captured, go to DONE.
- ALU contract relied on:
  - S=001 gives A+B+Cin.
  - S=010 gives A+~B+Cin with carry on Cout.
  - Sub therefore yields A−B mod 2^W, with `res_cout`=1 meaning no borrow.
- DONE: `res_valid`=1; `res_data`, `res_cout` and `res_err` are held stable until `res_ready`=1, then go to IDLE.
- Outside EXEC, `alu_a`, `alu_b`, `alu_s` and `alu_cin` are all driven 0.
- `cmd_*` inputs are ignored outside IDLE.
- Reset, asynchronous at any time including mid-EXEC: go to IDLE and discard any in-flight command; no result is produced.
- Reset values:
  - `cmd_ready`=1 (IDLE).
  - `res_valid`, `res_data`, `res_cout`, `res_err` and `res_zero` = 0.
  - `alu_*` outputs = 0.

## Timing
- Command accepted at edge k; EXEC spans cycles k+1..k+NIBBLES; `res_valid` rises after edge k+NIBBLES.
- Illegal opcode: `res_valid` rises after edge k (1-cycle latency).
- Result handshake completes at the edge where `res_valid && res_ready`. `cmd_ready` returns in the next cycle, so back-to-back issue is one command per NIBBLES+2 cycles.
- `res_ready` may be held high permanently; DONE then lasts exactly one cycle.
- `cmd_ready` is a function of state only and never depends combinationally on `cmd_valid`.
- The ALU path is combinational out and back in within one cycle: `alu_*` outputs are register-driven and `alu_f`/`alu_cout` are sampled at the same edge.

## Configuration
- `ALU_SEQ_ZFLAG_EN` defined:
  - `res_zero` is registered on entry to DONE as (`res_data` == 0) && !`res_err`.
  - It is valid with `res_valid` and held with it.
- `ALU_SEQ_ZFLAG_EN` undefined:
  - the `res_zero` port is still present and tied to 0.
  - no zero-detect logic is built.

## Test plan
- add, A=0xFFFF, B=0x0001 (NIBBLES=4) -> `res_data`=0x0000, `res_cout`=1; `res_valid` rises 4 cycles after accept; `alu_cin` sequence 0,1,1,1.
- sub, A=0x1234, B=0x0235 -> `res_data`=0x0FFF, `res_cout`=1. Then sub 0x0003−0x0007 -> `res_data`=0xFFFC, `res_cout`=0.
- XOR, A=0xA5A5, B=0x0FF0 -> `res_data`=0xAA55, `res_cout`=0. Then NOT A=0x00F0 -> 0xFF0F.
- Backpressure: hold `res_ready`=0 for 3 cycles after `res_valid` -> data/flags stable and `cmd_ready`=0 throughout; the command offered during that window is not accepted until IDLE.
- Opcode 111 -> `res_err`=1, `res_data`=0, `res_valid` one cycle after accept; no nonzero `alu_s` driven.
- Assert `rst_n`=0 during the second EXEC cycle of an add -> all outputs at reset values immediately; after release `cmd_ready`=1 and no `res_valid` pulse; `res_zero` checked =1 for pass A=0x0000 with `ALU_SEQ_ZFLAG_EN`, =0 without.
